// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request at a time and answers
// exactly LATENCY cycles later. Writes commit on acceptance; reads sample the word at response time.
module dmem_responder #(
   parameter int          LATENCY     = 2,
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h1ECE_B000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic        dmem_resp,
   output logic [31:0] dmem_rdata,
   output logic        busy,
   output logic        err,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count,
   output logic        o_dbg_state
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   // Handshake: a request is any cycle with a nonzero mask while IDLE or in the
   // dmem_resp cycle; the initiator keeps its masks steady until dmem_resp, and
   // inputs seen in WAIT before the response cycle are ignored.
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t          r_state, w_state_nxt;
   logic [3:0]      r_cnt, w_cnt_nxt;
   logic [AW-1:0]   r_idx;
   logic            r_is_read;
   logic            r_illegal;
   logic [31:0]     r_rd_count, r_wr_count;
   logic [31:0]     r_mem [DEPTH_WORDS];

   logic            w_is_rd, w_is_wr, w_has_req;
   logic [29:0]     w_word;
   logic            w_legal;
   logic            w_resp;
   logic            w_accept;
   logic            w_unused_ok;

   assign w_is_rd   = |dmem_rmask;
   assign w_is_wr   = |dmem_wmask;
   assign w_has_req = w_is_rd | w_is_wr;

   // Word index relative to BASE_ADDR; byte offset bits never matter.
   assign w_word  = dmem_addr[31:2] - BASE_ADDR[31:2];
   assign w_legal = (dmem_addr[31:2] >= BASE_ADDR[31:2]) &&
                    (w_word < 30'(DEPTH_WORDS)) && !(w_is_rd && w_is_wr);
   assign w_unused_ok = &{1'b0, dmem_addr[1:0]};

   assign w_resp   = rst && (r_state == WAIT) && (r_cnt == 4'd0);
   assign w_accept = rst && w_has_req && ((r_state == IDLE) || w_resp);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = WAIT;
               w_cnt_nxt   = 4'(LATENCY - 1);
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               if (w_accept) begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = 4'(LATENCY - 1);
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_idx      <= '0;
         r_is_read  <= 1'b0;
         r_illegal  <= 1'b0;
         r_rd_count <= 32'd0;
         r_wr_count <= 32'd0;
      end else begin
         if (w_accept) begin
            r_idx     <= w_word[AW-1:0];
            r_is_read <= w_is_rd;
            r_illegal <= !w_legal;
         end
         if (w_resp && !r_illegal) begin
            if (r_is_read && (r_rd_count != 32'hFFFF_FFFF))
               r_rd_count <= r_rd_count + 32'd1;
            if (!r_is_read && (r_wr_count != 32'hFFFF_FFFF))
               r_wr_count <= r_wr_count + 32'd1;
         end
      end
   end

   // Backing store survives reset; only legal writes touch it, lane by lane.
   always_ff @(posedge clk) begin
      if (w_accept && w_legal && w_is_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (dmem_wmask[i])
               r_mem[w_word[AW-1:0]][i*8 +: 8] <= dmem_wdata[i*8 +: 8];
         end
      end
   end

   assign dmem_resp   = w_resp;
   assign err         = w_resp && r_illegal;
   assign busy        = rst && (r_state == WAIT);
   assign dmem_rdata  = (w_resp && r_is_read && !r_illegal) ? r_mem[r_idx] : 32'd0;
   assign rd_count    = r_rd_count;
   assign wr_count    = r_wr_count;
   assign o_dbg_state = (r_state == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for write/read/error/reset
// behaviour, LATENCY=1 instance for back-to-back streaming.
module tb_dmem_responder;

   localparam logic [31:0] BASE = 32'h1ECE_B000;

   logic        clk;
   logic        rst;

   logic [31:0] a_addr, a_wdata, a_rdata, a_rdc, a_wrc;
   logic [3:0]  a_rmask, a_wmask;
   logic        a_resp, a_busy, a_err, a_dbg;

   logic [31:0] b_addr, b_wdata, b_rdata, b_rdc, b_wrc;
   logic [3:0]  b_rmask, b_wmask;
   logic        b_resp, b_busy, b_err, b_dbg;

   int n_checks;
   int n_fail;

   dmem_responder #(.LATENCY(2)) u_dut_a (
      .clk(clk), .rst(rst),
      .dmem_addr(a_addr), .dmem_rmask(a_rmask), .dmem_wmask(a_wmask), .dmem_wdata(a_wdata),
      .dmem_resp(a_resp), .dmem_rdata(a_rdata), .busy(a_busy), .err(a_err),
      .rd_count(a_rdc), .wr_count(a_wrc), .o_dbg_state(a_dbg)
   );

   dmem_responder #(.LATENCY(1)) u_dut_b (
      .clk(clk), .rst(rst),
      .dmem_addr(b_addr), .dmem_rmask(b_rmask), .dmem_wmask(b_wmask), .dmem_wdata(b_wdata),
      .dmem_resp(b_resp), .dmem_rdata(b_rdata), .busy(b_busy), .err(b_err),
      .rd_count(b_rdc), .wr_count(b_wrc), .o_dbg_state(b_dbg)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drivers: advance one cycle, drive the request, then park at the sample point.
   task automatic drive_a(input logic [31:0] addr, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd);
      @(posedge clk);
      #1;
      a_addr = addr; a_rmask = rm; a_wmask = wm; a_wdata = wd;
      @(negedge clk);
   endtask

   task automatic drive_b(input logic [31:0] addr, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd);
      @(posedge clk);
      #1;
      b_addr = addr; b_rmask = rm; b_wmask = wm; b_wdata = wd;
      @(negedge clk);
   endtask

   task automatic issue_a(input logic [31:0] addr, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd);
      drive_a(addr, rm, wm, wd);
      check_eq("a_accept_busy", 32'(a_busy), 0);
      check_eq("a_accept_resp", 32'(a_resp), 0);
   endtask

   // Masks dropped after acceptance; response due two cycles after acceptance.
   task automatic wait_resp_a(input string tag, input logic exp_err, input logic [31:0] exp_rd);
      drive_a(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq({tag, "_early_resp"}, 32'(a_resp), 0);
      check_eq({tag, "_busy1"}, 32'(a_busy), 1);
      drive_a(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq({tag, "_resp"}, 32'(a_resp), 1);
      check_eq({tag, "_err"}, 32'(a_err), 32'(exp_err));
      check_eq({tag, "_rdata"}, a_rdata, exp_rd);
      check_eq({tag, "_busy2"}, 32'(a_busy), 1);
      drive_a(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq({tag, "_late_resp"}, 32'(a_resp), 0);
      check_eq({tag, "_idle_busy"}, 32'(a_busy), 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0;
      a_addr = '0; a_rmask = '0; a_wmask = '0; a_wdata = '0;
      b_addr = '0; b_rmask = '0; b_wmask = '0; b_wdata = '0;

      // Reset with a request presented, which must be ignored
      drive_a(BASE + 32'd12, 4'h0, 4'hF, 32'h1234_5678);
      check_eq("rst_resp", 32'(a_resp), 0);
      check_eq("rst_busy", 32'(a_busy), 0);
      check_eq("rst_err", 32'(a_err), 0);
      check_eq("rst_rdata", a_rdata, 0);
      drive_a(32'd0, 4'h0, 4'h0, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check_eq("post_rst_busy", 32'(a_busy), 0);
      check_eq("post_rst_resp", 32'(a_resp), 0);
      check_eq("post_rst_rdc", a_rdc, 0);
      check_eq("post_rst_wrc", a_wrc, 0);

      // Full write then back-to-back read in the response cycle
      issue_a(BASE + 32'd8, 4'h0, 4'hF, 32'hDEAD_BEEF);
      drive_a(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq("w1_early_resp", 32'(a_resp), 0);
      check_eq("w1_busy", 32'(a_busy), 1);
      drive_a(BASE + 32'd8, 4'hF, 4'h0, 32'd0);
      check_eq("w1_resp", 32'(a_resp), 1);
      check_eq("w1_err", 32'(a_err), 0);
      check_eq("w1_rdata_zero", a_rdata, 0);
      drive_a(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq("r1_gap_resp", 32'(a_resp), 0);
      check_eq("r1_gap_busy", 32'(a_busy), 1);
      check_eq("w1_wrc", a_wrc, 1);
      drive_a(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq("r1_resp", 32'(a_resp), 1);
      check_eq("r1_rdata", a_rdata, 32'hDEAD_BEEF);
      drive_a(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq("r1_rdc", a_rdc, 1);
      check_eq("r1_done_busy", 32'(a_busy), 0);

      // Partial write to lane 2
      issue_a(BASE + 32'd8, 4'h0, 4'b0100, 32'h00AA_0000);
      wait_resp_a("w2", 1'b0, 32'd0);
      issue_a(BASE + 32'd8, 4'h1, 4'h0, 32'd0);
      wait_resp_a("r2", 1'b0, 32'hDEAA_BEEF);
      check_eq("r2_rdc", a_rdc, 2);
      check_eq("r2_wrc", a_wrc, 2);

      // Last legal word and illegal requests
      issue_a(BASE + 32'hFFC, 4'h0, 4'hF, 32'h5A5A_0F0F);
      wait_resp_a("w_last", 1'b0, 32'd0);
      issue_a(BASE + 32'hFFC, 4'hF, 4'h0, 32'd0);
      wait_resp_a("r_last", 1'b0, 32'h5A5A_0F0F);
      issue_a(BASE - 32'd4, 4'hF, 4'h0, 32'd0);
      wait_resp_a("below_base", 1'b1, 32'd0);
      issue_a(BASE + 32'h1000, 4'hF, 4'h0, 32'd0);
      wait_resp_a("past_end", 1'b1, 32'd0);
      issue_a(BASE + 32'd8, 4'hF, 4'h1, 32'hFFFF_FFFF);
      wait_resp_a("both_masks", 1'b1, 32'd0);
      check_eq("illegal_rdc", a_rdc, 3);
      check_eq("illegal_wrc", a_wrc, 3);
      issue_a(BASE + 32'd8, 4'hF, 4'h0, 32'd0);
      wait_resp_a("r_after_illegal", 1'b0, 32'hDEAA_BEEF);

      // Reset while a read is pending
      issue_a(BASE + 32'd8, 4'hF, 4'h0, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      a_rmask = 4'h0;
      @(negedge clk);
      check_eq("midrst_busy", 32'(a_busy), 0);
      check_eq("midrst_resp", 32'(a_resp), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_t2_resp", 32'(a_resp), 0);
      check_eq("midrst_t2_busy", 32'(a_busy), 0);
      check_eq("midrst_rdc", a_rdc, 0);
      check_eq("midrst_wrc", a_wrc, 0);
      drive_a(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq("midrst_t3_resp", 32'(a_resp), 0);
      issue_a(BASE + 32'd8, 4'hF, 4'h0, 32'd0);
      wait_resp_a("r_after_rst", 1'b0, 32'hDEAA_BEEF);
      check_eq("r_after_rst_rdc", a_rdc, 1);

      // LATENCY=1: one write, then four back-to-back reads with masks held
      drive_b(BASE, 4'h0, 4'hF, 32'h0BAD_F00D);
      check_eq("b_w_accept_resp", 32'(b_resp), 0);
      check_eq("b_w_accept_busy", 32'(b_busy), 0);
      drive_b(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq("b_w_resp", 32'(b_resp), 1);
      check_eq("b_w_rdata", b_rdata, 0);
      drive_b(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq("b_w_after", 32'(b_resp), 0);
      check_eq("b_wrc", b_wrc, 1);
      for (int i = 0; i < 4; i++) begin
         drive_b(BASE, 4'hF, 4'h0, 32'd0);
         check_eq("b_b2b_resp", 32'(b_resp), (i > 0) ? 1 : 0);
         check_eq("b_b2b_rdata", b_rdata, (i > 0) ? 32'h0BAD_F00D : 32'd0);
      end
      drive_b(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq("b_b2b_last_resp", 32'(b_resp), 1);
      check_eq("b_b2b_last_rdata", b_rdata, 32'h0BAD_F00D);
      drive_b(32'd0, 4'h0, 4'h0, 32'd0);
      check_eq("b_end_resp", 32'(b_resp), 0);
      check_eq("b_end_busy", 32'(b_busy), 0);
      check_eq("b_rdc", b_rdc, 4);
      check_eq("b_err", 32'(b_err), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
